// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/request and result/flag bundle for the pipelined logic unit
interface logic_unit_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic             all_ones;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, a, b, op, acc, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, parity, all_ones, acc_q
    );

    modport slave (
        input  in_valid, a, b, op, acc, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, parity, all_ones, acc_q
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage bitwise logic unit with optional accumulator, valid/ready handshakes
// and registered Zero/Parity/AllOnes flags that always track the driven Result.
module logic_unit_pipe #(
    parameter int WIDTH  = 4,
    parameter bit ACC_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);
    logic [WIDTH-1:0] a_eff, f;
    logic [WIDTH-1:0] s1_q, s1_d, res_q, res_d, acc_q, acc_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic             zero_q, zero_d, parity_q, parity_d, all_ones_q, all_ones_d;
    logic             s2_load, s2_take, rdy, accept;

    assign a_eff   = (ACC_EN && bus.acc) ? acc_q : bus.a;
    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s2_take = s2_load && s1_valid_q;
    assign rdy     = !s1_valid_q || s2_load;
    assign accept  = bus.in_valid && rdy;

    always_comb begin
        case (bus.op)
            3'b000:  f = a_eff ^ bus.b;
            3'b001:  f = a_eff & bus.b;
            3'b010:  f = a_eff | bus.b;
            3'b011:  f = ~(a_eff | bus.b);
            3'b100:  f = ~(a_eff & bus.b);
            3'b101:  f = ~(a_eff ^ bus.b);
            3'b110:  f = a_eff & ~bus.b;
            default: f = ~a_eff;
        endcase
    end

    // accumulator tracks at accept time so back-to-back Acc ops never see a stale value
    always_comb begin
        s1_valid_d = accept || (s1_valid_q && !s2_load);
        s1_d       = accept ? f : s1_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        res_d      = s2_take ? s1_q : res_q;
        zero_d     = s2_take ? ~|s1_q : zero_q;
        parity_d   = s2_take ? ^s1_q : parity_q;
        all_ones_d = s2_take ? &s1_q : all_ones_q;
        acc_d      = bus.acc_clr ? '0 : (ACC_EN && accept) ? f : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b1;
            parity_q   <= 1'b0;
            all_ones_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            parity_q   <= parity_d;
            all_ones_q <= all_ones_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.all_ones  = all_ones_q;
    assign bus.acc_q     = acc_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: random and directed stimulus against a truth-table scoreboard model
// for a WIDTH=4 accumulator build and a WIDTH=8 build without accumulator.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(4)) bus ();
    logic_unit_pipe_if #(.WIDTH(8)) bus8 ();

    logic_unit_pipe #(.WIDTH(4), .ACC_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // per-op truth table, bit index {a,b}
    logic [3:0] lut [8] = '{4'b0110, 4'b1000, 4'b1110, 4'b0001, 4'b0111, 4'b1001, 4'b0100, 4'b0011};

    int n_vec = 0;
    int n_err = 0;
    int ncyc = 0;
    int acc_cnt = 0;
    bit lat_chk = 0;
    logic [3:0] accm = '0;
    logic [7:0] exp_q [$];
    int         stamp_q [$];
    logic [3:0] seen [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input int w);
        logic [3:0] tt;
        logic [7:0] r;
        tt = lut[op];
        r = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic step(input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic acc, input logic clr, input logic ordy);
        logic [7:0] f;
        logic acpt;
        bus.in_valid = iv; bus.a = a; bus.b = b; bus.op = op;
        bus.acc = acc; bus.acc_clr = clr; bus.out_ready = ordy;
        #1;
        chk("acc_q", bus.acc_q, accm);
        chk("in_ready", bus.in_ready, exp_q.size() < 2 || ordy);
        if (exp_q.size() == 0) chk("out_valid_idle", bus.out_valid, 0);
        else if (bus.out_valid) begin
            chk("result", bus.result, exp_q[0]);
            chk("zero", bus.zero, exp_q[0] == 0);
            chk("parity", bus.parity, $countones(exp_q[0]) % 2);
            chk("all_ones", bus.all_ones, exp_q[0] == 8'h0F);
            if (ordy) begin
                if (lat_chk) chk("latency", ncyc - stamp_q[0], 2);
                seen.push_back(bus.result);
                exp_q.delete(0);
                stamp_q.delete(0);
            end
        end
        acpt = iv && bus.in_ready;
        f = '0;
        if (acpt) begin
            f = ref_f(op, {4'h0, acc ? accm : a}, {4'h0, b}, 4);
            exp_q.push_back(f);
            stamp_q.push_back(ncyc);
            acc_cnt++;
        end
        accm = clr ? 4'h0 : acpt ? f[3:0] : accm;
        ncyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops_exp [8];
        logic [7:0] a8, b8;
        logic [2:0] op8;
        int base, sb;
        ops_exp = '{4'h6, 4'h8, 4'hE, 4'h1, 4'h7, 4'h9, 4'h4, 4'h3};
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.op = 0; bus.acc = 0; bus.acc_clr = 0; bus.out_ready = 1;
        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.op = 0; bus8.acc = 0; bus8.acc_clr = 0; bus8.out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_parity", bus.parity, 0);
        chk("rst_all_ones", bus.all_ones, 0);
        chk("rst_acc_q", bus.acc_q, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // every op on A=1100 B=1010 at full throughput
        lat_chk = 1;
        base = seen.size();
        for (int i = 0; i < 8; i++) step(1'b1, 4'hC, 4'hA, 3'(i), 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("op_count", seen.size() - base, 8);
        if (seen.size() >= base + 8)
            for (int i = 0; i < 8; i++) chk("op_table", seen[base + i], ops_exp[i]);

        // accumulator chain
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'($urandom), 4'h1, 3'd2, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'($urandom), 4'h3, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'($urandom), 4'h0, 3'd7, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("chain_acc_q", bus.acc_q, 4'hD);
        if (seen.size() >= 3) begin
            chk("chain_r0", seen[seen.size() - 3], 4'h1);
            chk("chain_r1", seen[seen.size() - 2], 4'h2);
            chk("chain_r2", seen[seen.size() - 1], 4'hD);
        end

        // clear coinciding with an accept: op sees old AccQ, clear wins
        step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'h5, 4'h0, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'($urandom), 4'hF, 3'd1, 1'b1, 1'b1, 1'b1);
        chk("clr_acc_q", bus.acc_q, 4'h0);
        idle(3);
        if (seen.size() >= 1) chk("clr_result", seen[seen.size() - 1], 4'h5);

        // backpressure
        lat_chk = 0;
        base = acc_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        chk("bp_accepts", acc_cnt - base, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        sb = seen.size();
        idle(4);
        chk("bp_drain", seen.size() - sb, 2);

        // asynchronous reset with both stages full
        step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", bus.out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_acc_q", bus.acc_q, 0);
        chk("async_rst_zero", bus.zero, 1);
        chk("async_rst_result", bus.result, 0);
        exp_q.delete();
        stamp_q.delete();
        accm = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        chk("drain", exp_q.size(), 0);

        // WIDTH=8 build without accumulator
        for (int i = 0; i < 9; i++) begin
            a8 = (i == 0) ? 8'hF0 : 8'($urandom);
            b8 = (i == 0) ? 8'h0F : 8'($urandom);
            op8 = (i == 0) ? 3'd2 : 3'($urandom);
            bus8.in_valid = 1; bus8.a = a8; bus8.b = b8; bus8.op = op8; bus8.acc = 1; bus8.acc_clr = 0;
            @(negedge clk);
            bus8.in_valid = 0;
            @(negedge clk);
            #1;
            chk("w8_valid", bus8.out_valid, 1);
            chk("w8_result", bus8.result, ref_f(op8, a8, b8, 8));
            chk("w8_all_ones", bus8.all_ones, ref_f(op8, a8, b8, 8) == 8'hFF);
            chk("w8_acc_q", bus8.acc_q, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
